multicycle_core: RTL and testbench

Multi-cycle RV32I-subset processor core: the next generation of the team's single-cycle core. It replaces the separate instruction/data ports with one shared memory port using a req/ready handshake, so memory may insert wait states. Execution is sequenced by an explicit FSM, with parametrised reset vector and register-file depth (RV32I or RV32E). It sits between the SoC memory/interconnect and the debug/trace logic, which consumes `retire` and `halted`.

---
 rtl/multicycle_core_if.sv | 22 ++
 rtl/multicycle_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Shared instruction/data memory port of multicycle_core: req/ready handshake,
// one access per accepted request, wait states inserted by holding ready low.
interface multicycle_core_if;
    localparam int unsigned XLEN = 32;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV32E-subset core sequenced by an explicit FSM over a single
// shared memory port; reports retirement and sticky halt on illegal instructions.
module multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_core_if.master mem,
    output logic              retire,
    output logic              halted
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = $clog2(NUM_REGS);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R,
        EXEC_I, ALU_WB, BRANCH, JAL, LUI, HALT
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, old_pc, ir, a, b, alu_out, mdr;
    logic [XLEN-1:0] rf [NUM_REGS];

    logic            fire;
    logic            legal;
    logic            uses_rs1, uses_rs2, uses_rd;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign fire = mem.mem_req && mem.mem_ready;

    function automatic logic [XLEN-1:0] alu(input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y,
                                            input logic [2:0]      f3,
                                            input logic            sub);
        logic [XLEN-1:0] r;
        r = '0;
        case (f3)
            3'b000:  r = sub ? x - y : x + y;
            3'b111:  r = x & y;
            3'b110:  r = x | y;
            3'b010:  r = {31'b0, $signed(x) < $signed(y)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Legality of the latched instruction, including register-index range on RV32E.
    always_comb begin
        legal    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                legal    = (funct3 == 3'b010);
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            OP_STORE: begin
                legal    = (funct3 == 3'b010);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_REG: begin
                legal    = ((funct7 == 7'b0000000) &&
                            (funct3 == 3'b000 || funct3 == 3'b111 ||
                             funct3 == 3'b110 || funct3 == 3'b010)) ||
                           ((funct7 == 7'b0100000) && (funct3 == 3'b000));
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
            end
            OP_IMM: begin
                legal    = (funct3 == 3'b000 || funct3 == 3'b111 ||
                            funct3 == 3'b110 || funct3 == 3'b010);
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            OP_BRANCH: begin
                legal    = (funct3 == 3'b000 || funct3 == 3'b001);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                legal   = 1'b1;
                uses_rd = 1'b1;
            end
            OP_LUI: begin
                legal   = 1'b1;
                uses_rd = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (NUM_REGS == 16) begin
            if ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (uses_rd && rd[4]))
                legal = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (fire) state_nxt = DECODE;
            DECODE: begin
                if (!legal) state_nxt = HALT;
                else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_nxt = MEM_ADR;
                        OP_REG:            state_nxt = EXEC_R;
                        OP_IMM:            state_nxt = EXEC_I;
                        OP_BRANCH:         state_nxt = BRANCH;
                        OP_JAL:            state_nxt = JAL;
                        OP_LUI:            state_nxt = LUI;
                        default:           state_nxt = HALT;
                    endcase
                end
            end
            MEM_ADR: state_nxt = opcode[5] ? MEM_WR : MEM_RD;
            MEM_RD:  if (fire) state_nxt = MEM_WB;
            MEM_WR:  if (fire) state_nxt = FETCH;
            MEM_WB, ALU_WB, BRANCH, LUI: state_nxt = FETCH;
            EXEC_R, EXEC_I, JAL:         state_nxt = ALU_WB;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Request is gated by reset so an outstanding access is abandoned asynchronously.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = alu_out;
        mem.mem_wdata = '0;
        retire        = 1'b0;
        halted        = 1'b0;
        rf_we         = 1'b0;
        rf_wdata      = alu_out;
        case (state)
            FETCH: begin
                mem.mem_req  = reset;
                mem.mem_addr = pc;
            end
            MEM_RD: mem.mem_req = reset;
            MEM_WR: begin
                mem.mem_req   = reset;
                mem.mem_we    = 1'b1;
                mem.mem_wdata = b;
                retire        = mem.mem_ready;
            end
            MEM_WB: begin
                retire   = 1'b1;
                rf_we    = 1'b1;
                rf_wdata = mdr;
            end
            ALU_WB: begin
                retire = 1'b1;
                rf_we  = 1'b1;
            end
            BRANCH: retire = 1'b1;
            LUI: begin
                retire   = 1'b1;
                rf_we    = 1'b1;
                rf_wdata = {ir[31:12], 12'b0};
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            old_pc  <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                FETCH: if (fire) begin
                    ir     <= mem.mem_rdata;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end
                DECODE: begin
                    a       <= rf[rs1[RAW-1:0]];
                    b       <= rf[rs2[RAW-1:0]];
                    alu_out <= old_pc + ((opcode == OP_JAL) ? imm_j : imm_b);
                end
                MEM_ADR: alu_out <= a + (opcode[5] ? imm_s : imm_i);
                MEM_RD:  if (fire) mdr <= mem.mem_rdata;
                EXEC_R:  alu_out <= alu(a, b, funct3, ir[30]);
                EXEC_I:  alu_out <= alu(a, imm_i, funct3, 1'b0);
                BRANCH:  if ((a == b) ^ funct3[0]) pc <= alu_out;
                JAL: begin
                    pc      <= alu_out;
                    alu_out <= old_pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    // x0 is never written, so its reset value keeps it reading zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= '0;
        end else if (rf_we && (rd[RAW-1:0] != '0)) begin
            rf[rd[RAW-1:0]] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: RV32I core at 0x100 plus an RV32E core
// that must halt on an out-of-range register index.
module tb_multicycle_core;
    logic clk;
    logic reset, reset_e;
    logic ready;
    logic retire, halted, retire_e, halted_e;

    logic [31:0] ram   [256];
    logic [31:0] ram_e [16];

    int ncmp = 0, nfail = 0;
    int cyc = 0, nret = 0, nret_e = 0, last_ret = 0;
    int ret_cyc [32];
    int f_cyc, r1;

    multicycle_core_if bus ();
    multicycle_core_if bus_e ();

    assign bus.mem_ready   = ready;
    assign bus.mem_rdata   = ram[bus.mem_addr[9:2]];
    assign bus_e.mem_ready = 1'b1;
    assign bus_e.mem_rdata = ram_e[bus_e.mem_addr[5:2]];

    multicycle_core #(.RESET_PC(32'h0000_0100), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .mem(bus), .retire(retire), .halted(halted)
    );

    multicycle_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(16)) dut_e (
        .clk(clk), .reset(reset_e), .mem(bus_e), .retire(retire_e), .halted(halted_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] im;
        im = 32'(imm);
        return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] im;
        im = 32'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im;
        im = 32'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] im;
        im = 32'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        ram[addr[9:2]] = word;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: commit a completing store, then sample just after the edge.
    task automatic step();
        if (bus.mem_req && bus.mem_we && bus.mem_ready)
            ram[bus.mem_addr[9:2]] = bus.mem_wdata;
        @(posedge clk);
        #1;
        cyc++;
        if (retire) begin
            if (nret < 32) ret_cyc[nret] = cyc;
            nret++;
            last_ret = cyc;
        end
        if (retire_e) nret_e++;
    endtask

    task automatic wait_fetch(input logic [31:0] addr, input int budget, input string tag);
        int n = 0;
        while (!(bus.mem_req && !bus.mem_we && bus.mem_addr == addr) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(bus.mem_req && !bus.mem_we && bus.mem_addr == addr), 32'd1);
        f_cyc = cyc;
    endtask

    task automatic wait_retire(input int budget, input string tag);
        int n0 = nret;
        int n  = 0;
        step();
        n++;
        while (nret == n0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(nret != n0), 32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        reset_e = 1'b0;
        ready   = 1'b1;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        for (int i = 0; i < 16; i++) ram_e[i] = 32'h0;

        ram[5]  = 32'hDEAD_BEEF;
        ram[7]  = 32'hFFFF_FFFF;
        ram[8]  = 32'h1111_1111;
        ram[10] = 32'hA5A5_A5A5;
        ram[11] = 32'h5555_5555;
        ram[14] = 32'h0000_0077;
        ram[20] = 32'h6666_6666;

        put(32'h100, addi(1, 0, 5));
        put(32'h104, addi(2, 0, -3));
        put(32'h108, enc_r(0, 2, 1, 0, 3));
        put(32'h10C, enc_s(8, 3, 0));
        put(32'h110, enc_i(8, 0, 2, 4, 7'b0000011));
        put(32'h114, enc_s(12, 4, 0));
        put(32'h118, enc_i(20, 0, 2, 6, 7'b0000011));
        put(32'h11C, enc_s(16, 6, 0));
        put(32'h120, enc_b(8, 1, 1, 1));
        put(32'h124, enc_b(8, 0, 0, 0));
        put(32'h128, addi(7, 0, 1));
        put(32'h12C, enc_j(16, 5));
        put(32'h130, addi(7, 0, 2));
        put(32'h134, addi(7, 0, 3));
        put(32'h138, addi(7, 0, 4));
        put(32'h13C, enc_b(8, 0, 0, 0));
        put(32'h140, enc_b(8, 0, 0, 0));
        put(32'h144, enc_b(-4, 0, 0, 0));
        put(32'h148, enc_s(24, 5, 0));
        put(32'h14C, enc_s(28, 7, 0));
        put(32'h150, addi(0, 0, 7));
        put(32'h154, enc_s(32, 0, 0));
        put(32'h158, {20'h12345, 5'd10, 7'b0110111});
        put(32'h15C, enc_s(36, 10, 0));
        put(32'h160, enc_r(32, 2, 1, 0, 11));
        put(32'h164, enc_s(48, 11, 0));
        put(32'h168, enc_r(0, 1, 2, 2, 12));
        put(32'h16C, enc_s(52, 12, 0));
        put(32'h170, enc_i(-1, 1, 2, 13, 7'b0010011));
        put(32'h174, enc_s(56, 13, 0));
        put(32'h178, enc_r(0, 2, 1, 7, 14));
        put(32'h17C, enc_s(60, 14, 0));
        put(32'h180, enc_r(0, 2, 1, 6, 15));
        put(32'h184, enc_s(64, 15, 0));
        put(32'h188, enc_i(32'h0F0, 2, 7, 16, 7'b0010011));
        put(32'h18C, enc_s(68, 16, 0));
        put(32'h190, enc_i(32'h700, 1, 6, 17, 7'b0010011));
        put(32'h194, enc_s(72, 17, 0));
        put(32'h198, enc_i(0, 2, 2, 19, 7'b0010011));
        put(32'h19C, enc_s(76, 19, 0));
        put(32'h1A0, enc_s(40, 3, 0));

        ram_e[0] = addi(1, 0, 1);
        ram_e[1] = enc_r(0, 2, 1, 0, 20);
        ram_e[2] = addi(2, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_req",    32'(bus.mem_req), 32'd0);
        check("rst_we",     32'(bus.mem_we), 32'd0);
        check("rst_addr",   bus.mem_addr, 32'h100);
        check("rst_wdata",  bus.mem_wdata, 32'h0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        @(posedge clk);
        #1;
        reset   = 1'b1;
        reset_e = 1'b1;
        cyc     = 1;
        #1;
        check("first_req",  32'(bus.mem_req), 32'd1);
        check("first_addr", bus.mem_addr, 32'h100);

        for (int k = 0; k < 5; k++) wait_retire(10, "seq_retire");
        check("ret_addi1", 32'(ret_cyc[0]), 32'd4);
        check("ret_addi2", 32'(ret_cyc[1]), 32'd8);
        check("ret_add",   32'(ret_cyc[2]), 32'd12);
        check("ret_sw",    32'(ret_cyc[3]), 32'd16);
        check("ret_lw",    32'(ret_cyc[4]), 32'd21);
        check("word2",     ram[2], 32'd2);

        // Load with three wait states in MEM_RD.
        wait_fetch(32'h118, 20, "fetch_lw_stall");
        repeat (3) step();
        ready = 1'b0;
        #1;
        check("stall_req",  32'(bus.mem_req), 32'd1);
        check("stall_we",   32'(bus.mem_we), 32'd0);
        check("stall_addr", bus.mem_addr, 32'd20);
        step();
        check("stall_addr1", bus.mem_addr, 32'd20);
        step();
        check("stall_addr2", bus.mem_addr, 32'd20);
        check("stall_req2",  32'(bus.mem_req), 32'd1);
        step();
        ready = 1'b1;
        wait_retire(5, "lw_stall_retire");
        check("lw_stall_cycles", 32'(last_ret - f_cyc + 1), 32'd8);

        wait_fetch(32'h120, 20, "fetch_bne");
        wait_retire(5, "bne_retire");
        check("bne_cycles", 32'(last_ret - f_cyc + 1), 32'd3);
        step();
        check("bne_not_taken", bus.mem_addr, 32'h124);
        wait_retire(5, "beq_fwd_retire");
        step();
        check("beq_fwd_taken", bus.mem_addr, 32'h12C);
        f_cyc = cyc;
        wait_retire(6, "jal_retire");
        check("jal_cycles", 32'(last_ret - f_cyc + 1), 32'd4);
        step();
        check("jal_target", bus.mem_addr, 32'h13C);
        wait_retire(5, "beq2_retire");
        step();
        check("beq2_target", bus.mem_addr, 32'h144);
        wait_retire(5, "beq_back_retire");
        step();
        check("beq_back_target", bus.mem_addr, 32'h140);
        wait_retire(5, "beq3_retire");
        step();
        check("beq3_target", bus.mem_addr, 32'h148);

        // Final store stalls in MEM_WR and is cut off by reset.
        wait_fetch(32'h1A0, 200, "fetch_sw_stall");
        repeat (3) step();
        ready = 1'b0;
        #1;
        check("wr_req",    32'(bus.mem_req), 32'd1);
        check("wr_we",     32'(bus.mem_we), 32'd1);
        check("wr_addr",   bus.mem_addr, 32'd40);
        check("wr_wdata",  bus.mem_wdata, 32'd2);
        check("wr_retire", 32'(retire), 32'd0);
        step();
        check("wr_addr_hold",  bus.mem_addr, 32'd40);
        check("wr_wdata_hold", bus.mem_wdata, 32'd2);
        check("no_halt",       32'(halted), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus.mem_req), 32'd0);
        ready = 1'b1;

        check("w_lw_x4",   ram[3],  32'd2);
        check("w_lw_stall", ram[4], 32'hDEAD_BEEF);
        check("w_jal_x5",  ram[6],  32'h130);
        check("w_skipped", ram[7],  32'h0);
        check("w_x0",      ram[8],  32'h0);
        check("w_lui",     ram[9],  32'h1234_5000);
        check("w_abandon", ram[10], 32'hA5A5_A5A5);
        check("w_sub",     ram[12], 32'd8);
        check("w_slt",     ram[13], 32'd1);
        check("w_slti",    ram[14], 32'd0);
        check("w_and",     ram[15], 32'd5);
        check("w_or",      ram[16], 32'hFFFF_FFFD);
        check("w_andi",    ram[17], 32'h0F0);
        check("w_ori",     ram[18], 32'h705);
        check("w_slti_neg", ram[19], 32'd1);

        put(32'h100, enc_s(44, 3, 0));
        put(32'h104, enc_s(80, 5, 0));
        put(32'h108, enc_b(0, 0, 0, 0));
        repeat (2) step();

        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 1;
        #1;
        check("restart_req",  32'(bus.mem_req), 32'd1);
        check("restart_addr", bus.mem_addr, 32'h100);

        wait_fetch(32'h108, 20, "fetch_self_loop");
        wait_retire(5, "loop_retire1");
        r1 = last_ret;
        wait_retire(5, "loop_retire2");
        check("loop_period", 32'(last_ret - r1), 32'd3);
        step();
        check("loop_addr", bus.mem_addr, 32'h108);
        check("w_x3_reset", ram[11], 32'h0);
        check("w_x5_reset", ram[20], 32'h0);

        check("e_halted", 32'(halted_e), 32'd1);
        check("e_req",    32'(bus_e.mem_req), 32'd0);
        check("e_retire_count", 32'(nret_e), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
